apb_master_bridge: RTL and testbench

- Upstream APB master stage that feeds the ApbBus master side, i.e. the input of the APB multiplexer.
- Converts a simple valid/ready request/response stream into APB3 transfers: one outstanding transfer at a time.
- Bounds each access with a wait-state timeout so a dead slave never hangs the host side.
- The request stream comes from the host-command path (UART/Ethernet decoder).

---
 rtl/apb_master_bridge_pkg.sv | 27 ++
 rtl/apb_master_bridge_if.sv | 24 ++
 rtl/apb_master_bridge_core.sv | 152 +++++++++++++++
 rtl/apb_master_bridge.sv | 62 ++++++
 tb/tb_apb_master_bridge.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_bridge_pkg.sv
// rtl/apb_master_bridge_pkg.sv - shared types and default widths for the APB master bridge
package apb_pkg;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;
    localparam int APB_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_t;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  error;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - APB3 bus bundle with master and slave views
interface apb_bus #(
    parameter int AddrWidth = 16,
    parameter int DataWidth = 32
) ();
    logic [AddrWidth-1:0] paddr;
    logic                 psel;
    logic                 penable;
    logic                 pwrite;
    logic [DataWidth-1:0] pwdata;
    logic                 pready;
    logic [DataWidth-1:0] prdata;
    logic                 pslverror;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata, pslverror
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata, pslverror
    );
endinterface

// File: rtl/apb_master_bridge_core.sv
// rtl/apb_master_bridge_core.sv - request/response to APB3 sequencer with wait-state timeout
module apb_master_bridge_core
    import apb_pkg::*;
#(
    parameter int AddrWidth     = APB_ADDR_W,
    parameter int DataWidth     = APB_DATA_W,
    parameter int TimeoutCycles = APB_TIMEOUT_CYCLES
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic                 req_write,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    apb_bus.master               bus
);

    localparam int CntWidth = $clog2(TimeoutCycles + 1);
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TimeoutCycles);

    apb_master_state_t    state_q, state_d;
    logic [AddrWidth-1:0] paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [DataWidth-1:0] pwdata_q, pwdata_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_error_q, rsp_error_d;
    logic                 rsp_timeout_q, rsp_timeout_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [CntWidth-1:0]  cnt_inc;

    // Next-state and next-output computation; the wait counter saturates at the limit.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_error_d   = rsp_error_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        cnt_inc       = (cnt_q == CntLimit) ? cnt_q : cnt_q + CntWidth'(1);

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    paddr_d     = req_addr;
                    pwrite_d    = req_write;
                    pwdata_d    = req_wdata;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    req_ready_d = 1'b0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A ready slave takes priority over a counter expiring on the same edge.
                if (bus.pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                    rsp_error_d   = bus.pslverror;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntLimit) begin
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_error_d   = 1'b0;
                        rsp_timeout_d = 1'b1;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset discards any transfer in flight.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign bus.paddr   = paddr_q;
    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.pwdata  = pwdata_q;

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - flat-port wrapper mapping APB pins onto the bus bundle
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int AddrWidth     = APB_ADDR_W,
    parameter int DataWidth     = APB_DATA_W,
    parameter int TimeoutCycles = APB_TIMEOUT_CYCLES
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic                 req_write,
    input  logic [DataWidth-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_rdata,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    output logic [AddrWidth-1:0] PADDR,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [DataWidth-1:0] PWDATA,
    input  logic                 PREADY,
    input  logic [DataWidth-1:0] PRDATA,
    input  logic                 PSLVERROR
);

    apb_bus #(.AddrWidth(AddrWidth), .DataWidth(DataWidth)) bus ();

    assign PADDR         = bus.paddr;
    assign PSEL          = bus.psel;
    assign PENABLE       = bus.penable;
    assign PWRITE        = bus.pwrite;
    assign PWDATA        = bus.pwdata;
    assign bus.pready    = PREADY;
    assign bus.prdata    = PRDATA;
    assign bus.pslverror = PSLVERROR;

    apb_master_bridge_core #(
        .AddrWidth    (AddrWidth),
        .DataWidth    (DataWidth),
        .TimeoutCycles(TimeoutCycles)
    ) u_core (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .bus        (bus.master)
    );

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for the APB master bridge
module tb_apb_master_bridge;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          rsp_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    apb_bus #(.AddrWidth(AW), .DataWidth(DW)) slv ();

    apb_master_bridge #(
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .TimeoutCycles(4)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .PADDR      (slv.paddr),
        .PSEL       (slv.psel),
        .PENABLE    (slv.penable),
        .PWRITE     (slv.pwrite),
        .PWDATA     (slv.pwdata),
        .PREADY     (slv.pready),
        .PRDATA     (slv.prdata),
        .PSLVERROR  (slv.pslverror)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_psel"}, DW'(slv.psel), 0);
        chk({tag, "_penable"}, DW'(slv.penable), 0);
    endtask

    task automatic send(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_addr  = a;
        req_write = w;
        req_wdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        PRESETn       = 1'b0;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_write     = 1'b0;
        req_wdata     = '0;
        rsp_ready     = 1'b0;
        slv.pready    = 1'b0;
        slv.prdata    = '0;
        slv.pslverror = 1'b0;
        tick();
        tick();

        // Reset values
        chk_idle_bus("rst");
        chk("rst_pwrite", DW'(slv.pwrite), 0);
        chk("rst_paddr", DW'(slv.paddr), 0);
        chk("rst_pwdata", slv.pwdata, 0);
        chk("rst_req_ready", DW'(req_ready), 0);
        chk("rst_rsp_valid", DW'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_error", DW'(rsp_error), 0);
        chk("rst_rsp_timeout", DW'(rsp_timeout), 0);
        PRESETn = 1'b1;
        tick();
        chk("idle_req_ready", DW'(req_ready), 1);

        // 1: zero-wait write of 0xDEADBEEF to 123
        rsp_ready  = 1'b1;
        slv.pready = 1'b1;
        send(16'd123, 1'b1, 32'hDEADBEEF);
        tick();
        req_valid = 1'b0;
        chk("t1_setup_psel", DW'(slv.psel), 1);
        chk("t1_setup_penable", DW'(slv.penable), 0);
        chk("t1_paddr", DW'(slv.paddr), 123);
        chk("t1_pwrite", DW'(slv.pwrite), 1);
        chk("t1_pwdata", slv.pwdata, 32'hDEADBEEF);
        chk("t1_req_ready", DW'(req_ready), 0);
        tick();
        chk("t1_access_psel", DW'(slv.psel), 1);
        chk("t1_access_penable", DW'(slv.penable), 1);
        chk("t1_no_early_rsp", DW'(rsp_valid), 0);
        tick();
        chk("t1_rsp_valid", DW'(rsp_valid), 1);
        chk("t1_rsp_error", DW'(rsp_error), 0);
        chk("t1_rsp_timeout", DW'(rsp_timeout), 0);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        chk_idle_bus("t1_after");
        chk("t1_paddr_hold", DW'(slv.paddr), 123);
        tick();
        chk("t1_rsp_done", DW'(rsp_valid), 0);
        chk("t1_req_ready_back", DW'(req_ready), 1);

        // 2: read from 10 with 3 wait states; the 4th ACCESS edge also hits the timeout limit
        slv.pready = 1'b0;
        send(16'd10, 1'b0, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("t2_paddr", DW'(slv.paddr), 10);
        chk("t2_pwrite", DW'(slv.pwrite), 0);
        tick();
        chk("t2_penable_c1", DW'(slv.penable), 1);
        tick();
        chk("t2_penable_c2", DW'(slv.penable), 1);
        tick();
        chk("t2_penable_c3", DW'(slv.penable), 1);
        tick();
        chk("t2_penable_c4", DW'(slv.penable), 1);
        chk("t2_rsp_not_yet", DW'(rsp_valid), 0);
        slv.pready = 1'b1;
        slv.prdata = 32'd255;
        tick();
        slv.pready = 1'b0;
        slv.prdata = 32'h0000AAAA;
        chk_idle_bus("t2_after");
        chk("t2_rsp_valid", DW'(rsp_valid), 1);
        chk("t2_rsp_rdata", rsp_rdata, 255);
        chk("t2_rsp_error", DW'(rsp_error), 0);
        chk("t2_rsp_timeout", DW'(rsp_timeout), 0);
        tick();
        chk("t2_rsp_done", DW'(rsp_valid), 0);

        // 3: slave error on an unmapped read
        slv.pready    = 1'b1;
        slv.pslverror = 1'b1;
        slv.prdata    = 32'h00001234;
        send(16'h7FF0, 1'b0, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        slv.pslverror = 1'b0;
        chk("t3_rsp_valid", DW'(rsp_valid), 1);
        chk("t3_rsp_error", DW'(rsp_error), 1);
        chk("t3_rsp_timeout", DW'(rsp_timeout), 0);
        chk("t3_rsp_rdata", rsp_rdata, 32'h00001234);
        tick();
        chk("t3_rsp_done", DW'(rsp_valid), 0);

        // 4: dead slave, TimeoutCycles=4
        slv.pready = 1'b0;
        slv.prdata = 32'hFFFF0000;
        send(16'h0020, 1'b0, 32'h0);
        tick();
        req_valid = 1'b0;
        tick();
        chk("t4_penable_c1", DW'(slv.penable), 1);
        tick();
        tick();
        tick();
        chk("t4_penable_c4", DW'(slv.penable), 1);
        chk("t4_rsp_not_yet", DW'(rsp_valid), 0);
        tick();
        chk_idle_bus("t4_after");
        chk("t4_rsp_valid", DW'(rsp_valid), 1);
        chk("t4_rsp_timeout", DW'(rsp_timeout), 1);
        chk("t4_rsp_error", DW'(rsp_error), 0);
        chk("t4_rsp_rdata", rsp_rdata, 0);
        tick();
        slv.pready = 1'b1;
        send(16'h0030, 1'b1, 32'h00000055);
        tick();
        req_valid = 1'b0;
        chk("t4b_paddr", DW'(slv.paddr), 32'h30);
        tick();
        tick();
        chk("t4b_rsp_valid", DW'(rsp_valid), 1);
        chk("t4b_rsp_timeout", DW'(rsp_timeout), 0);
        chk("t4b_rsp_rdata", rsp_rdata, 0);
        tick();

        // 5: response backpressure with a second request held pending
        rsp_ready  = 1'b0;
        slv.pready = 1'b1;
        slv.prdata = 32'h0000CAFE;
        send(16'h0040, 1'b0, 32'h0);
        tick();
        send(16'h0050, 1'b1, 32'h00000011);
        tick();
        tick();
        slv.prdata = 32'h0BADF00D;
        for (int i = 0; i < 10; i++) begin
            chk("t5_rsp_valid_hold", DW'(rsp_valid), 1);
            chk("t5_rsp_rdata_hold", rsp_rdata, 32'h0000CAFE);
            chk("t5_req_ready_low", DW'(req_ready), 0);
            tick();
        end
        chk("t5_paddr_hold", DW'(slv.paddr), 32'h40);
        rsp_ready = 1'b1;
        tick();
        chk("t5_rsp_done", DW'(rsp_valid), 0);
        chk("t5_req_ready", DW'(req_ready), 1);
        chk("t5_not_accepted_yet", DW'(slv.psel), 0);
        tick();
        req_valid = 1'b0;
        chk("t5b_psel", DW'(slv.psel), 1);
        chk("t5b_paddr", DW'(slv.paddr), 32'h50);
        chk("t5b_pwdata", slv.pwdata, 32'h00000011);
        tick();
        tick();
        chk("t5b_rsp_valid", DW'(rsp_valid), 1);
        chk("t5b_rsp_rdata", rsp_rdata, 0);
        tick();

        // 6: reset during ACCESS, then a fresh write to 456
        slv.pready = 1'b0;
        send(16'h0070, 1'b1, 32'h00000099);
        tick();
        req_valid = 1'b0;
        tick();
        chk("t6_in_access", DW'(slv.penable), 1);
        PRESETn = 1'b0;
        tick();
        chk_idle_bus("t6_rst");
        chk("t6_rst_pwrite", DW'(slv.pwrite), 0);
        chk("t6_rst_paddr", DW'(slv.paddr), 0);
        chk("t6_rst_pwdata", slv.pwdata, 0);
        chk("t6_rst_req_ready", DW'(req_ready), 0);
        chk("t6_rst_rsp_valid", DW'(rsp_valid), 0);
        PRESETn    = 1'b1;
        slv.pready = 1'b1;
        tick();
        chk("t6_no_stale_rsp", DW'(rsp_valid), 0);
        chk("t6_req_ready", DW'(req_ready), 1);
        send(16'd456, 1'b1, 32'h00000456);
        tick();
        req_valid = 1'b0;
        chk("t6_paddr", DW'(slv.paddr), 456);
        chk("t6_pwdata", slv.pwdata, 32'h00000456);
        tick();
        tick();
        chk("t6_rsp_valid", DW'(rsp_valid), 1);
        chk("t6_rsp_error", DW'(rsp_error), 0);
        chk("t6_rsp_timeout", DW'(rsp_timeout), 0);
        tick();
        chk("t6_rsp_done", DW'(rsp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
